// File: rtl/camac_cycle_sequencer.sv
// CAMAC dataway cycle sequencer: turns a host select into setup / S1 / (gap / S2) / hold
// phases timed by a tick enable, with X latch, cycle watchdog and a synchronised LAM interrupt.
module camac_cycle_sequencer #(
    parameter int ADDR_WIDTH  = 2,
    parameter int PHASE_WIDTH = 4,
    parameter int T_SETUP     = 2,
    parameter int T_S1        = 4,
    parameter int T_GAP       = 2,
    parameter int T_S2        = 4,
    parameter int T_HOLD      = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic                  w,
    input  logic                  sel,
    input  logic                  tim,
    input  logic                  ie,
    input  logic                  lam,
    input  logic                  cx1,
    output logic                  rdy,
    output logic                  c1,
    output logic                  c2,
    output logic                  sel2,
    output logic [ADDR_WIDTH-1:0] a_q,
    output logic                  w_q,
    output logic                  x1,
    output logic                  x0,
    output logic                  irq
);

    localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

    localparam logic [PHASE_WIDTH-1:0] LD_SETUP = PHASE_WIDTH'(T_SETUP - 1);
    localparam logic [PHASE_WIDTH-1:0] LD_S1    = PHASE_WIDTH'(T_S1 - 1);
    localparam logic [PHASE_WIDTH-1:0] LD_GAP   = PHASE_WIDTH'(T_GAP - 1);
    localparam logic [PHASE_WIDTH-1:0] LD_S2    = PHASE_WIDTH'(T_S2 - 1);
    localparam logic [PHASE_WIDTH-1:0] LD_HOLD  = PHASE_WIDTH'(T_HOLD - 1);
    localparam logic [WD_WIDTH-1:0]    WD_LAST  = WD_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE1, GAP, STROBE2, HOLD, DONE
    } state_t;

    state_t                  state, state_d;
    logic [PHASE_WIDTH-1:0]  cnt, cnt_d;
    logic [WD_WIDTH-1:0]     wdog, wdog_d;
    logic [ADDR_WIDTH-1:0]   a_d;
    logic                    w_d, x1_d, x0_d;
    logic                    active, busy_d, phase_end;
    logic                    lam_meta, lam_sync;

    assign active    = (state != IDLE) && (state != DONE);
    assign phase_end = tim && (cnt == '0);
    assign busy_d    = state_d inside {SETUP, STROBE1, GAP, STROBE2, HOLD};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state;
        cnt_d   = cnt;
        wdog_d  = wdog;
        a_d     = a_q;
        w_d     = w_q;
        x1_d    = x1;
        x0_d    = x0;

        if (active && tim && (cnt != '0)) cnt_d = cnt - PHASE_WIDTH'(1);
        if (active)                       wdog_d = wdog + WD_WIDTH'(1);

        case (state)
            IDLE: if (sel) begin
                state_d = SETUP;
                a_d     = a;
                w_d     = w;
                x1_d    = 1'b0;
                x0_d    = 1'b0;
                cnt_d   = LD_SETUP;
                wdog_d  = '0;
            end
            SETUP: if (phase_end) begin
                state_d = STROBE1;
                cnt_d   = LD_S1;
            end
            STROBE1: if (phase_end) begin
                x1_d = cx1;
                x0_d = ~cx1;
                if (w_q) begin
                    state_d = GAP;
                    cnt_d   = LD_GAP;
                end else begin
                    state_d = HOLD;
                    cnt_d   = LD_HOLD;
                end
            end
            GAP: if (phase_end) begin
                state_d = STROBE2;
                cnt_d   = LD_S2;
            end
            STROBE2: if (phase_end) begin
                state_d = HOLD;
                cnt_d   = LD_HOLD;
            end
            HOLD: if (phase_end) begin
                state_d = DONE;
                cnt_d   = '0;
            end
            DONE: if (!sel) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A stuck tick must not hang the host: watchdog overrides any phase decision.
        if (active && (wdog == WD_LAST)) begin
            state_d = DONE;
            cnt_d   = '0;
            x1_d    = 1'b0;
            x0_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            wdog  <= '0;
            a_q   <= '0;
            w_q   <= 1'b0;
            x1    <= 1'b0;
            x0    <= 1'b0;
            c1    <= 1'b0;
            c2    <= 1'b0;
            sel2  <= 1'b0;
            rdy   <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state <= state_d;
            cnt   <= cnt_d;
            wdog  <= wdog_d;
            a_q   <= a_d;
            w_q   <= w_d;
            x1    <= x1_d;
            x0    <= x0_d;
            c1    <= (state_d == STROBE1);
            c2    <= (state_d == STROBE2);
            sel2  <= busy_d;
            rdy   <= ~busy_d;
        end
    end

    // LAM arrives from the crate asynchronously; two flops, then the gated output flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lam_meta <= 1'b0;
            lam_sync <= 1'b0;
            irq      <= 1'b0;
        end else begin
            lam_meta <= lam;
            lam_sync <= lam_meta;
            irq      <= ie & lam_sync;
        end
    end

endmodule

// File: doc/camac_cycle_sequencer.md
# camac_cycle_sequencer

Parametrised successor to the SM2201 ISA–CAMAC micro-program automaton. Converts a host-side select request into a timed CAMAC dataway cycle: setup, S1 strobe, an optional S2 strobe for writes, and hold. Phase lengths, address width and watchdog limit are parameters. It also adds a tick-gated phase timer, an X-response latch, a cycle watchdog and a synchronised LAM interrupt path. It sits between the ISA address/command decoder and the CAMAC dataway drivers on the interface board.

## Interface
- ADDR_WIDTH, 2, width of register address `a`
- PHASE_WIDTH, 4, width of the phase counter; every T_* must be ≤ 2^PHASE_WIDTH
- T_SETUP, 2, setup phase length in ticks (≥1)
- T_S1, 4, S1 strobe length in ticks (≥1)
- T_GAP, 2, gap between S1 and S2 in ticks (≥1, writes only)
- T_S2, 4, S2 strobe length in ticks (≥1, writes only)
- T_HOLD, 2, hold phase length in ticks (≥1)
- TIMEOUT, 64, watchdog limit in clk cycles (≥ sum of the active phase lengths)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- a  in  ADDR_WIDTH  register address, captured at cycle start
- w  in  1  direction: 1 = write, 0 = read; captured at cycle start
- sel  in  1  board select / cycle request (level)
- tim  in  1  timing tick enable; phase counters advance only when 1
- ie  in  1  interrupt enable
- lam  in  1  asynchronous LAM request from crate
- cx1  in  1  CAMAC X (command accepted) response
- rdy  out  1  ISA ready; 0 while a cycle is in progress
- c1  out  1  S1 strobe
- c2  out  1  S2 strobe
- sel2  out  1  dataway busy (B)
- a_q  out  ADDR_WIDTH  latched address
- w_q  out  1  latched direction
- x1  out  1  X received in last cycle
- x0  out  1  last cycle ended without X, or by watchdog
- irq  out  1  interrupt request

## Operation
- States: IDLE, SETUP, STROBE1, GAP, STROBE2, HOLD, DONE.
- Reset values: state IDLE, rdy=1, c1=c2=sel2=0, a_q=0, w_q=0, x0=x1=0, irq=0, and all counters 0.
- IDLE→SETUP when sel=1. On that edge: capture a→a_q and w→w_q, clear x0/x1, load the phase counter with T_SETUP−1, and clear the watchdog.
- Phase counter: on a cycle with tim=1, decrement if nonzero, else leave the phase. On a cycle with tim=0, hold.
- Phase transitions:
  - SETUP→STROBE1.
  - STROBE1→GAP if w_q=1, else →HOLD.
  - GAP→STROBE2.
  - STROBE2→HOLD.
  - HOLD→DONE.
- Each phase entry loads its own T−1.
- X latch: cx1 is sampled on the STROBE1 exit edge. x1 takes cx1; x0 takes ~cx1.
- DONE→IDLE when sel=0. DONE with sel still 1 stays in DONE, so there is no retrigger until sel drops.
- sel dropping mid-cycle does not abort the cycle. The cycle completes, then DONE→IDLE on the next edge.
- Watchdog: counts every clk in SETUP..HOLD regardless of tim. On reaching TIMEOUT−1, force the next state to DONE, set x0=1 and x1=0, and drop c1/c2.
- irq = ie AND lam after a 2-flop synchroniser, registered. It is independent of the cycle state.
- Reset asserted mid-cycle returns all outputs to their reset values immediately, asynchronously.

## Timing
- All outputs are registered and aligned with the state register:
  - c1=1 exactly in STROBE1.
  - c2=1 exactly in STROBE2.
  - sel2=1 in SETUP..HOLD.
  - rdy=0 in SETUP..HOLD, rdy=1 in IDLE/DONE.
- With tim held at 1 and sel sampled high at edge k:
  - c1 is high for edges k+2..k+6 (T_S1=4 cycles).
  - Read: rdy returns to 1 after edge k+8 (T_SETUP+T_S1+T_HOLD).
  - Write: c2 is high for 4 cycles starting after edge k+8; rdy returns to 1 after edge k+14.
- Each tim=0 cycle stretches the current phase by exactly one clk.
- irq latency from a lam edge is 3 clk.

## Test plan
- Read, tim=1, w=0, a=2, sel high at edge k: c1 high 4 cycles, c2 never high, a_q=2, rdy low 8 cycles; cx1=1 during S1 gives x1=1, x0=0.
- Write, tim=1, w=1, cx1=0: c1 4 cycles, 2-cycle gap, c2 4 cycles, rdy low 14 cycles; x1=0, x0=1.
- tim toggling 1/0 each clk during a read: every phase doubles in length, rdy low 16 cycles, no glitch on c1.
- tim stuck at 0 after SETUP: watchdog fires 64 cycles after start, state DONE, x0=1, c1=c2=0, rdy=1.
- sel held high after DONE: no second cycle; sel dropped for 1 clk then raised: new cycle starts. reset pulled low while c1 is high: all outputs go to reset values at once.
- lam=1 with ie=0: irq stays 0; set ie=1: irq=1 within 3 clk; lam=0: irq=0 within 3 clk.
